// File: rtl/leb128_reader.sv
// LEB128 integer reader (ULEB128/SLEB128, up to 32 bits) acting as initiator on a byte-wide ROM port.
// Returns the decoded value and the address just past the encoding, or an error pulse.
//
//   state  | meaning
//   S_IDLE | waiting for start; outputs held
//   S_REQ  | rom_read_en high, address stable, timeout running
//   S_GAP  | one cycle with rom_read_en low between byte fetches
//   S_FIN  | done or error pulse cycle, then back to idle
module leb128_reader #(
   parameter int ADDR_W    = 32,
   parameter int MAX_BYTES = 5,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic              signed_mode_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [31:0]       value_o,
   output logic [ADDR_W-1:0] next_addr_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic              rom_read_en_o,
   input  logic [7:0]        rom_data_i,
   input  logic              rom_ready_i
);

   localparam int IDX_W = $clog2(MAX_BYTES + 1);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int SH_W  = $clog2(7 * MAX_BYTES + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_FIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [ADDR_W-1:0] next_addr_q, next_addr_d;
   logic [31:0]       value_q, value_d;
   logic [31:0]       acc_q, acc_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [SH_W-1:0]   sh_q, sh_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              signed_q, signed_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic [31:0]       chunk;
   logic [31:0]       acc_sum;
   logic [31:0]       ext_mask;
   logic [SH_W-1:0]   sh_new;
   logic              last_byte;
   logic              bad_last;

   always_comb begin
      chunk    = 32'(rom_data_i[6:0]) << sh_q;
      acc_sum  = acc_q | chunk;
      sh_new   = sh_q + SH_W'(7);
      ext_mask = '0;
      if (signed_q && rom_data_i[6] && (sh_new < SH_W'(32))) begin
         ext_mask = 32'hFFFF_FFFF << sh_new;
      end
      last_byte = (idx_q == IDX_W'(MAX_BYTES - 1));
      // On the final byte only the bits that still fit in 32 may carry information.
      bad_last  = last_byte &&
                  (rom_data_i[7] ||
                   (signed_q ? (rom_data_i[6:4] != {3{rom_data_i[3]}})
                             : (rom_data_i[6:4] != 3'b000)));
   end

   always_comb begin
      state_d     = state_q;
      rom_addr_d  = rom_addr_q;
      next_addr_d = next_addr_q;
      value_d     = value_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      sh_d        = sh_q;
      tmo_d       = tmo_q;
      signed_d    = signed_q;
      done_d      = 1'b0;
      error_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               rom_addr_d = start_addr_i;
               signed_d   = signed_mode_i;
               acc_d      = '0;
               idx_d      = '0;
               sh_d       = '0;
               tmo_d      = TMO_W'(TIMEOUT - 1);
               state_d    = S_REQ;
            end
         end
         S_REQ: begin
            if (rom_ready_i) begin
               rom_addr_d = rom_addr_q + ADDR_W'(1);
               idx_d      = idx_q + IDX_W'(1);
               sh_d       = sh_new;
               acc_d      = acc_sum;
               tmo_d      = TMO_W'(TIMEOUT - 1);
               if (bad_last) begin
                  error_d     = 1'b1;
                  value_d     = '0;
                  next_addr_d = rom_addr_q + ADDR_W'(1);
                  state_d     = S_FIN;
               end else if (!rom_data_i[7]) begin
                  done_d      = 1'b1;
                  value_d     = acc_sum | ext_mask;
                  next_addr_d = rom_addr_q + ADDR_W'(1);
                  state_d     = S_FIN;
               end else begin
                  state_d = S_GAP;
               end
            end else if (tmo_q == '0) begin
               error_d     = 1'b1;
               value_d     = '0;
               next_addr_d = rom_addr_q;
               state_d     = S_FIN;
            end else begin
               tmo_d = tmo_q - TMO_W'(1);
            end
         end
         S_GAP: begin
            tmo_d   = TMO_W'(TIMEOUT - 1);
            state_d = S_REQ;
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rom_addr_q  <= '0;
         next_addr_q <= '0;
         value_q     <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         sh_q        <= '0;
         tmo_q       <= '0;
         signed_q    <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rom_addr_q  <= rom_addr_d;
         next_addr_q <= next_addr_d;
         value_q     <= value_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         sh_q        <= sh_d;
         tmo_q       <= tmo_d;
         signed_q    <= signed_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign busy_o        = (state_q != S_IDLE);
   assign rom_read_en_o = (state_q == S_REQ);
   assign done_o        = done_q;
   assign error_o       = error_q;
   assign value_o       = value_q;
   assign next_addr_o   = next_addr_q;
   assign rom_addr_o    = rom_addr_q;

endmodule

// File: doc/leb128_reader.md
Name: leb128_reader

Overview:
- Initiator on the byte-wide ROM read interface. It fetches a LEB128-encoded integer (unsigned or signed, up to 32 bits) starting at a given ROM address.
- Returns the decoded value and the address of the first byte after the encoding.
- Sits between the wasm loader's section/opcode parsing logic and the ROM. It replaces ad-hoc byte fetch loops for counts, indices, sizes and i32 immediates.

Parameters:
- ADDR_W, 32, width of ROM byte address.
- MAX_BYTES, 5, maximum encoded length accepted (ceil(32/7)).
- TIMEOUT, 255, cycles to wait for rom_ready per byte before flagging error.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to decode; sampled only in IDLE.
- start_addr  input  ADDR_W  address of first encoded byte; sampled with start.
- signed_mode  input  1  1 = SLEB128 (sign-extend), 0 = ULEB128; sampled with start.
- busy  output  1  high from cycle after accepted start until done/error cycle inclusive.
- done  output  1  one-cycle pulse: value/next_addr valid.
- error  output  1  one-cycle pulse: malformed encoding or timeout.
- value  output  32  decoded result; held until next accepted start.
- next_addr  output  ADDR_W  address after last consumed byte; held until next accepted start.
- rom_addr  output  ADDR_W  byte address to ROM.
- rom_read_en  output  1  read request to ROM.
- rom_data  input  8  byte from ROM, valid in the rom_ready cycle.
- rom_ready  input  1  one-cycle pulse from ROM: rom_data valid.

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy=0, done=0, error=0, value=0, next_addr=0, rom_addr=0, rom_read_en=0. Byte index, shift and timeout counter cleared. Reset mid-decode abandons the transaction; no done/error is emitted.
- FSM states: IDLE, REQ, GAP, FIN.
- IDLE: on start=1, latch start_addr into rom_addr and signed_mode, clear accumulator and index, then go to REQ. start is ignored in every other state.
- REQ: rom_read_en=1 and rom_addr held stable until rom_ready. On rom_ready:
  - OR rom_data[6:0] into accumulator at bit 7*idx (bits above 31 discarded).
  - idx+1; rom_addr+1.
  - If rom_data[7]=0, go to FIN. Otherwise go to GAP.
- GAP: rom_read_en=0 for exactly one cycle, then back to REQ with the incremented address. Each new request therefore presents a different address to the ROM.
- Byte idx 4 (5th byte) has extra rules:
  - rom_data[7]=1 is an error.
  - Unsigned: rom_data[6:4] != 0 is an error.
  - Signed: rom_data[6:4] must all equal rom_data[3], else error.
  - Encodings longer than MAX_BYTES are never read past byte MAX_BYTES.
- FIN (1 cycle):
  - If signed and the final byte's bit6=1 and 7*(idx) < 32, sign-extend value from bit 7*idx-1.
  - Drive done=1, latch value and next_addr=rom_addr, then return to IDLE.
- Error path: error=1 for one cycle, value=0, next_addr=address of offending byte +1, return to IDLE.
- Timeout: counter runs in REQ, cleared on each rom_ready. Reaching TIMEOUT raises error, with next_addr = current rom_addr.
- done and error are never asserted together. busy falls the cycle after done/error.
- rom_ready outside REQ is ignored.
- Latency: start to first rom_read_en = 1 cycle. Per byte = ROM response time + 1 GAP cycle. Last rom_ready to done = 1 cycle.
- Address arithmetic wraps modulo 2^ADDR_W.

Test Plan:
- ULEB single byte: ROM[0x10]=0x05, start_addr=0x10 -> done, value=0x00000005, next_addr=0x11, exactly one read.
- ULEB multi-byte: ROM[0x20..0x22]=E5 8E 26 -> value=624485 (0x00098765), next_addr=0x23. rom_read_en is low for exactly one cycle between reads.
- SLEB: 0x7F -> value=0xFFFFFFFF. C0 BB 78 -> value=0xFFFE1DC0 (-123456). Same 0x7F unsigned -> 0x0000007F.
- Max length: FF FF FF FF 0F unsigned -> value=0xFFFFFFFF, next_addr=start+5. 80 80 80 80 80 -> error pulse, value=0, no 6th read. FF FF FF FF 1F unsigned -> error.
- Timeout/handshake: ROM never raises rom_ready -> error exactly TIMEOUT cycles after rom_read_en rises, busy drops next cycle. A start pulse while busy does not restart or change rom_addr.
- Reset mid-op: assert rst_n=0 during the 2nd byte of E5 8E 26 -> all outputs 0 immediately. After release, a new start decodes 0x05 correctly.
